// File: rtl/status_register_ctx.sv
// STATUS register with masked firmware writes, per-flag ALU updates,
// event-driven n_TO/n_PD bits and a LIFO shadow stack for interrupt context.
// The stack saves the full register on interrupt entry. On RETFIE it restores
// every bit except n_TO/n_PD, which always reflect the live power/watchdog state.
module status_register_ctx #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'('h18),
   parameter logic [WIDTH-1:0] WR_MASK   = WIDTH'('hE7),
   parameter int unsigned      DEPTH     = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       status_wr,
   input  logic [WIDTH-1:0]           status_reg_in,
   input  logic [2:0]                 flag_wr_en,
   input  logic [2:0]                 flag_in,
   input  logic                       sleep_evt,
   input  logic                       clrwdt_evt,
   input  logic                       wdt_to_evt,
   input  logic                       ctx_push,
   input  logic                       ctx_pop,
   input  logic                       err_clr,
   output logic [WIDTH-1:0]           status_reg_out,
   output logic                       irp,
   output logic [1:0]                 rp,
   output logic                       n_to,
   output logic                       n_pd,
   output logic                       z,
   output logic                       dc,
   output logic                       c,
   output logic [$clog2(DEPTH+1)-1:0] ctx_level,
   output logic                       ctx_overflow,
   output logic                       ctx_underflow
);

   localparam int unsigned LW = $clog2(DEPTH + 1);

   // Bits 4:3 (n_TO, n_PD) are owned by the event logic alone.
   localparam logic [WIDTH-1:0] EVT_BITS     = WIDTH'('h18);
   localparam logic [WIDTH-1:0] WR_EFF       = WR_MASK & ~EVT_BITS;
   localparam logic [WIDTH-1:0] RESTORE_MASK = ~EVT_BITS;
   localparam logic [LW-1:0]    FULL_LEVEL   = LW'(DEPTH);

   logic [WIDTH-1:0] status_reg, status_next;
   logic [LW-1:0]    level_reg, level_next;
   logic             overflow_reg, overflow_next;
   logic             underflow_reg, underflow_next;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] stack_top;

   logic push_only, pop_only, push_ok, pop_ok;

   // Classify this cycle's stack request.
   always_comb begin
      push_only = ctx_push & ~ctx_pop;
      pop_only  = ctx_pop & ~ctx_push;
      push_ok   = push_only & (level_reg != FULL_LEVEL);
      pop_ok    = pop_only & (level_reg != '0);
   end

   // Stack entries: each one captures the pre-edge STATUS when it is the next free slot.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
         logic [WIDTH-1:0] entry_reg;

         // Write this entry on a push that targets it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               entry_reg <= '0;
            else if (push_ok && (level_reg == LW'(gi)))
               entry_reg <= status_reg;
         end

         assign stack_q[gi] = entry_reg;
      end
   endgenerate

   // Select the top-of-stack entry (entry[level-1]) for restore.
   always_comb begin
      stack_top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (level_reg == LW'(i + 1))
            stack_top = stack_q[i];
      end
   end

   // Next STATUS: restore, else masked firmware write then per-flag ALU override;
   // n_TO/n_PD follow events only.
   always_comb begin
      status_next = status_reg;
      if (pop_ok) begin
         status_next = (stack_top & RESTORE_MASK) | (status_reg & EVT_BITS);
      end else begin
         if (status_wr)
            status_next = (status_reg_in & WR_EFF) | (status_reg & ~WR_EFF);
         for (int i = 0; i < 3; i++) begin
            if (flag_wr_en[i])
               status_next[i] = flag_in[i];
         end
      end
      if (wdt_to_evt) begin
         status_next[4] = 1'b0;
      end else if (sleep_evt) begin
         status_next[4] = 1'b1;
         status_next[3] = 1'b0;
      end else if (clrwdt_evt) begin
         status_next[4] = 1'b1;
         status_next[3] = 1'b1;
      end
   end

   // Next stack level and sticky error flags; a new error beats err_clr.
   always_comb begin
      level_next = level_reg;
      if (push_ok)
         level_next = level_reg + LW'(1);
      else if (pop_ok)
         level_next = level_reg - LW'(1);

      overflow_next  = overflow_reg & ~err_clr;
      underflow_next = underflow_reg & ~err_clr;
      if (push_only && (level_reg == FULL_LEVEL))
         overflow_next = 1'b1;
      if ((pop_only && (level_reg == '0)) || (ctx_push && ctx_pop))
         underflow_next = 1'b1;
   end

   // Register state; reset is asynchronous so the register is valid without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_reg    <= RESET_VAL;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         status_reg    <= status_next;
         level_reg     <= level_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign status_reg_out = status_reg;
   assign irp            = status_reg[7];
   assign rp             = status_reg[6:5];
   assign n_to           = status_reg[4];
   assign n_pd           = status_reg[3];
   assign z              = status_reg[2];
   assign dc             = status_reg[1];
   assign c              = status_reg[0];
   assign ctx_level      = level_reg;
   assign ctx_overflow   = overflow_reg;
   assign ctx_underflow  = underflow_reg;

endmodule

// File: tb/tb_status_register_ctx.sv
// Bench for status_register_ctx: directed scenarios against hand-derived
// constants, then randomized traffic against a queue-based reference model.
module tb_status_register_ctx;

   localparam int DEPTH = 2;
   localparam logic [7:0] WR_MASK = 8'hE7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       status_wr;
   logic [7:0] status_reg_in;
   logic [2:0] flag_wr_en, flag_in;
   logic       sleep_evt, clrwdt_evt, wdt_to_evt;
   logic       ctx_push, ctx_pop, err_clr;
   logic [7:0] status_reg_out;
   logic       irp, n_to, n_pd, z, dc, c;
   logic [1:0] rp;
   logic [1:0] ctx_level;
   logic       ctx_overflow, ctx_underflow;

   int checks = 0;
   int errors = 0;

   // Reference model: register value, stack as a queue, sticky flags.
   logic [7:0] m_status;
   logic [7:0] m_stack[$];
   bit         m_ovf, m_unf;

   status_register_ctx #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .status_wr(status_wr), .status_reg_in(status_reg_in),
      .flag_wr_en(flag_wr_en), .flag_in(flag_in), .sleep_evt(sleep_evt),
      .clrwdt_evt(clrwdt_evt), .wdt_to_evt(wdt_to_evt), .ctx_push(ctx_push),
      .ctx_pop(ctx_pop), .err_clr(err_clr), .status_reg_out(status_reg_out),
      .irp(irp), .rp(rp), .n_to(n_to), .n_pd(n_pd), .z(z), .dc(dc), .c(c),
      .ctx_level(ctx_level), .ctx_overflow(ctx_overflow), .ctx_underflow(ctx_underflow)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      status_wr = 0; status_reg_in = '0; flag_wr_en = '0; flag_in = '0;
      sleep_evt = 0; clrwdt_evt = 0; wdt_to_evt = 0;
      ctx_push = 0; ctx_pop = 0; err_clr = 0;
   endtask

   task automatic model_reset();
      m_status = 8'h18;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
   endtask

   // Apply one clock's worth of the register rules to the model.
   task automatic model_step();
      logic [7:0] nxt;
      logic [7:0] top;
      bit set_ovf, set_unf;
      nxt = m_status;
      set_ovf = 0;
      set_unf = 0;
      if (ctx_pop && !ctx_push && m_stack.size() > 0) begin
         top = m_stack.pop_back();
         nxt = {top[7:5], m_status[4:3], top[2:0]};
      end else begin
         if (ctx_pop && !ctx_push) set_unf = 1;
         if (status_wr) nxt = (status_reg_in & WR_MASK) | (m_status & ~WR_MASK);
         for (int i = 0; i < 3; i++) if (flag_wr_en[i]) nxt[i] = flag_in[i];
      end
      if (ctx_push && !ctx_pop) begin
         if (m_stack.size() < DEPTH) m_stack.push_back(m_status);
         else set_ovf = 1;
      end
      if (ctx_push && ctx_pop) set_unf = 1;
      if (wdt_to_evt) nxt[4] = 0;
      else if (sleep_evt) begin nxt[4] = 1; nxt[3] = 0; end
      else if (clrwdt_evt) begin nxt[4] = 1; nxt[3] = 1; end
      if (err_clr) begin m_ovf = 0; m_unf = 0; end
      if (set_ovf) m_ovf = 1;
      if (set_unf) m_unf = 1;
      m_status = nxt;
   endtask

   // One cycle: step the model on the driven inputs, clock, then sample on the falling edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic wr(input logic [7:0] d);
      status_wr = 1; status_reg_in = d; tick();
   endtask

   task automatic test_reset();
      #1 rst_n = 0;
      #1;
      model_reset();
      checks++; if (status_reg_out !== 8'h18) begin errors++; $display("FAIL reset_status: got %h want 18", status_reg_out); end
      checks++; if (ctx_level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", ctx_level); end
      checks++; if ({ctx_overflow, ctx_underflow} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {ctx_overflow, ctx_underflow}); end
      @(negedge clk);
      rst_n = 1;
      repeat (3) tick();
      checks++; if (status_reg_out !== 8'h18 || ctx_level !== 2'd0) begin errors++; $display("FAIL reset_idle: got %h/%0d want 18/0", status_reg_out, ctx_level); end
      $display("reset: status=%h level=%0d", status_reg_out, ctx_level);
   endtask

   task automatic test_masked_write();
      wr(8'hFF);
      checks++; if (status_reg_out !== 8'hFF) begin errors++; $display("FAIL masked_ff: got %h want ff", status_reg_out); end
      status_wr = 1; status_reg_in = 8'h00; flag_wr_en = 3'b100; flag_in = 3'b100; tick();
      checks++; if (status_reg_out !== 8'h1C) begin errors++; $display("FAIL masked_flag: got %h want 1c", status_reg_out); end
      $display("masked write: status=%h", status_reg_out);
   endtask

   task automatic test_events();
      sleep_evt = 1; tick();
      checks++; if ({n_to, n_pd} !== 2'b10) begin errors++; $display("FAIL evt_sleep: got %b want 10", {n_to, n_pd}); end
      wdt_to_evt = 1; clrwdt_evt = 1; tick();
      checks++; if ({n_to, n_pd} !== 2'b00) begin errors++; $display("FAIL evt_wdt: got %b want 00", {n_to, n_pd}); end
      status_wr = 1; status_reg_in = 8'hFF; tick();
      checks++; if ({n_to, n_pd} !== 2'b00) begin errors++; $display("FAIL evt_wr_ignored: got %b want 00", {n_to, n_pd}); end
      clrwdt_evt = 1; tick();
      checks++; if ({n_to, n_pd} !== 2'b11) begin errors++; $display("FAIL evt_clrwdt: got %b want 11", {n_to, n_pd}); end
      $display("events: status=%h", status_reg_out);
   endtask

   task automatic test_nested();
      wr(8'h61);
      ctx_push = 1; tick();
      checks++; if (ctx_level !== 2'd1) begin errors++; $display("FAIL nest_l1: got %0d want 1", ctx_level); end
      wr(8'h25);
      ctx_push = 1; tick();
      checks++; if (ctx_level !== 2'd2) begin errors++; $display("FAIL nest_l2: got %0d want 2", ctx_level); end
      wr(8'h00);
      ctx_pop = 1; tick();
      checks++; if (status_reg_out !== 8'h3D || ctx_level !== 2'd1) begin errors++; $display("FAIL nest_pop1: got %h/%0d want 3d/1", status_reg_out, ctx_level); end
      ctx_pop = 1; tick();
      checks++; if (status_reg_out !== 8'h79 || ctx_level !== 2'd0) begin errors++; $display("FAIL nest_pop2: got %h/%0d want 79/0", status_reg_out, ctx_level); end
      $display("nested: status=%h level=%0d", status_reg_out, ctx_level);
   endtask

   task automatic test_over_under();
      wr(8'h01); ctx_push = 1; tick();
      wr(8'h02); ctx_push = 1; tick();
      wr(8'h04); ctx_push = 1; tick();
      checks++; if (ctx_level !== 2'd2 || ctx_overflow !== 1'b1) begin errors++; $display("FAIL ovf: got %0d/%b want 2/1", ctx_level, ctx_overflow); end
      wr(8'h40);
      ctx_pop = 1; tick();
      checks++; if (status_reg_out !== 8'h1A) begin errors++; $display("FAIL ovf_entry1: got %h want 1a", status_reg_out); end
      ctx_pop = 1; tick();
      checks++; if (status_reg_out !== 8'h19) begin errors++; $display("FAIL ovf_entry0: got %h want 19", status_reg_out); end
      ctx_pop = 1; tick();
      checks++; if (status_reg_out !== 8'h19 || ctx_level !== 2'd0 || ctx_underflow !== 1'b1) begin errors++; $display("FAIL unf: got %h/%0d/%b want 19/0/1", status_reg_out, ctx_level, ctx_underflow); end
      err_clr = 1; ctx_pop = 1; tick();
      checks++; if ({ctx_overflow, ctx_underflow} !== 2'b01) begin errors++; $display("FAIL clr_vs_set: got %b want 01", {ctx_overflow, ctx_underflow}); end
      err_clr = 1; tick();
      checks++; if ({ctx_overflow, ctx_underflow} !== 2'b00) begin errors++; $display("FAIL err_clr: got %b want 00", {ctx_overflow, ctx_underflow}); end
      $display("over/under: status=%h level=%0d", status_reg_out, ctx_level);
   endtask

   task automatic test_conflicts();
      wr(8'h80); ctx_push = 1; tick();
      wr(8'h00);
      ctx_pop = 1; status_wr = 1; status_reg_in = 8'hFF; flag_wr_en = 3'b111; flag_in = 3'b111; tick();
      checks++; if (status_reg_out !== 8'h98 || ctx_level !== 2'd0) begin errors++; $display("FAIL pop_wins: got %h/%0d want 98/0", status_reg_out, ctx_level); end
      ctx_push = 1; tick();
      ctx_push = 1; ctx_pop = 1; status_wr = 1; status_reg_in = 8'h21; tick();
      checks++; if (status_reg_out !== 8'h39 || ctx_level !== 2'd1 || ctx_underflow !== 1'b1) begin errors++; $display("FAIL push_pop: got %h/%0d/%b want 39/1/1", status_reg_out, ctx_level, ctx_underflow); end
      err_clr = 1; tick();
      $display("conflicts: status=%h level=%0d", status_reg_out, ctx_level);
   endtask

   task automatic test_async_reset();
      wr(8'hA0);
      ctx_push = 1; status_wr = 1; status_reg_in = 8'h47;
      #2 rst_n = 0;
      #1;
      checks++; if (status_reg_out !== 8'h18 || ctx_level !== 2'd0 || ctx_underflow !== 1'b0) begin errors++; $display("FAIL async_rst: got %h/%0d/%b want 18/0/0", status_reg_out, ctx_level, ctx_underflow); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      clear_inputs();
      model_reset();
      checks++; if (status_reg_out !== 8'h18 || ctx_level !== 2'd0) begin errors++; $display("FAIL rst_hold: got %h/%0d want 18/0", status_reg_out, ctx_level); end
      ctx_pop = 1; tick();
      checks++; if (status_reg_out !== 8'h18 || ctx_underflow !== 1'b1) begin errors++; $display("FAIL rst_stack_lost: got %h/%b want 18/1", status_reg_out, ctx_underflow); end
      $display("async reset: status=%h level=%0d", status_reg_out, ctx_level);
   endtask

   task automatic test_random();
      int bad = 0;
      for (int n = 0; n < 400; n++) begin
         status_wr     = ($urandom_range(0, 2) == 0);
         status_reg_in = 8'($urandom);
         flag_wr_en    = 3'($urandom);
         flag_in       = 3'($urandom);
         sleep_evt     = ($urandom_range(0, 9) == 0);
         clrwdt_evt    = ($urandom_range(0, 9) == 0);
         wdt_to_evt    = ($urandom_range(0, 11) == 0);
         ctx_push      = ($urandom_range(0, 3) == 0);
         ctx_pop       = ($urandom_range(0, 3) == 0);
         err_clr       = ($urandom_range(0, 7) == 0);
         tick();
         checks++;
         if (status_reg_out !== m_status || ctx_level !== 2'(m_stack.size()) ||
             ctx_overflow !== m_ovf || ctx_underflow !== m_unf ||
             {irp, rp, n_to, n_pd, z, dc, c} !== m_status) begin
            errors++; bad++;
            $display("FAIL random[%0d]: got st=%h lvl=%0d ovf=%b unf=%b bits=%h want st=%h lvl=%0d ovf=%b unf=%b",
                     n, status_reg_out, ctx_level, ctx_overflow, ctx_underflow,
                     {irp, rp, n_to, n_pd, z, dc, c}, m_status, m_stack.size(), m_ovf, m_unf);
         end
      end
      $display("random: 400 cycles, %0d bad", bad);
   endtask

   initial begin
      clear_inputs();
      model_reset();
      test_reset();
      test_masked_write();
      test_events();
      test_nested();
      test_over_under();
      test_conflicts();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
